multree_pipe: RTL and testbench

- Unsigned 58x58-bit significand multiplier for the FPU multiply/divide datapath; produces the full 116-bit product.
- Partial products are reduced by a carry-save adder tree to a sum/carry pair, then resolved by a final carry-propagate adder.
- Two-stage pipeline with valid tracking: accepts one operand pair per cycle, returns each product 2 cycles later.

---
 rtl/fpu_mul_pkg.sv | 32 +++
 rtl/csa32.sv | 19 +
 rtl/multree_pipe.sv | 70 +++++++
 tb/tb_multree_pipe.sv | 110 +++++++++++
 4 files changed

// File: rtl/fpu_mul_pkg.sv
// rtl/fpu_mul_pkg.sv - shared widths, types and CSA tree sizing helpers for the significand multiplier
package fpu_mul_pkg;

    localparam int MUL_W  = 58;
    localparam int PROD_W = 2 * MUL_W;

    typedef logic [MUL_W-1:0]  mul_op_t;
    typedef logic [PROD_W-1:0] mul_prod_t;

    // Rows remaining after l levels of 3:2 reduction; leftover rows pass straight through.
    function automatic int tree_rows(input int w, input int l);
        int n;
        n = w;
        for (int k = 0; k < l; k++) begin
            n = 2 * (n / 3) + n % 3;
        end
        return n;
    endfunction

    function automatic int tree_levels(input int w);
        int n;
        int k;
        n = w;
        k = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            k++;
        end
        return k;
    endfunction

endpackage

// File: rtl/csa32.sv
// rtl/csa32.sv - parameterised 3:2 carry-save adder, carry pre-shifted into weight position
module csa32 #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    logic [W-1:0] w_maj;

    assign w_maj = (x & y) | (x & z) | (y & z);
    assign s     = x ^ y ^ z;
    // The majority bit out of the MSB falls off: the product fits in W bits anyway.
    assign c     = w_maj << 1;

endmodule

// File: rtl/multree_pipe.sv
// rtl/multree_pipe.sv - two-stage unsigned multiplier: CSA tree to sum/carry, then final add
module multree_pipe
    import fpu_mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    output logic [2*W-1:0]   out
);

    localparam int PW = 2 * W;
    localparam int LV = tree_levels(W);

    logic [PW-1:0] w_sum;
    logic [PW-1:0] w_carry;
    logic [PW-1:0] r_sum;
    logic [PW-1:0] r_carry;
    logic          r_v1;

    // Each level owns its row array; level l reads the rows of level l-1.
    for (genvar l = 0; l <= LV; l++) begin : g_lvl
        localparam int N = tree_rows(W, l);
        logic [PW-1:0] w_v [N];

        if (l == 0) begin : g_pp
            for (genvar i = 0; i < W; i++) begin : g_row
                assign w_v[i] = b[i] ? ({{W{1'b0}}, a} << i) : '0;
            end
        end else begin : g_red
            localparam int NP = tree_rows(W, l - 1);
            for (genvar j = 0; j < NP / 3; j++) begin : g_csa
                csa32 #(.W(PW)) u_csa (
                    .x (g_lvl[l-1].w_v[3*j]),
                    .y (g_lvl[l-1].w_v[3*j+1]),
                    .z (g_lvl[l-1].w_v[3*j+2]),
                    .s (w_v[2*j]),
                    .c (w_v[2*j+1])
                );
            end
            for (genvar r = 0; r < NP % 3; r++) begin : g_pass
                assign w_v[2*(NP/3)+r] = g_lvl[l-1].w_v[3*(NP/3)+r];
            end
        end
    end

    assign w_sum   = g_lvl[LV].w_v[0];
    assign w_carry = g_lvl[LV].w_v[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum     <= '0;
            r_carry   <= '0;
            r_v1      <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            r_sum     <= w_sum;
            r_carry   <= w_carry;
            r_v1      <= in_valid;
            out       <= r_sum + r_carry;
            out_valid <= r_v1;
        end
    end

endmodule

// File: tb/tb_multree_pipe.sv
// tb/tb_multree_pipe.sv - directed and streamed vector bench for multree_pipe
module tb_multree_pipe;
    import fpu_mul_pkg::*;

    logic      clk;
    logic      rst;
    logic      in_valid;
    mul_op_t   a;
    mul_op_t   b;
    logic      out_valid;
    mul_prod_t out;

    int n_vec;
    int n_bad;

    logic      pv [2];
    mul_prod_t pe [2];

    multree_pipe #(.W(MUL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input mul_prod_t obs, input mul_prod_t exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: check what the previous edges produced, then drive the next inputs.
    task automatic step(input logic r, input logic v, input mul_op_t ta, input mul_op_t tb,
                        input mul_prod_t te, input logic zchk, input string tag);
        @(negedge clk);
        check("out_valid", mul_prod_t'(out_valid), mul_prod_t'(pv[1]));
        if (pv[1]) check(tag, out, pe[1]);
        if (zchk) check("out_zero", out, '0);
        rst      = r;
        in_valid = v;
        a        = ta;
        b        = tb;
        pv[1]    = r ? 1'b0 : pv[0];
        pe[1]    = pe[0];
        pv[0]    = v && !r;
        pe[0]    = te;
    endtask

    initial begin
        mul_op_t   ra;
        mul_op_t   rb;
        mul_op_t   pa;
        mul_op_t   pb;
        mul_prod_t e_ext;
        n_vec = 0;
        n_bad = 0;
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        pe[0] = '0;
        pe[1] = '0;
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 58'd5;
        b        = 58'd7;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 58'd5, 58'd7, '0, 1'b1, "rst");
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, "rst");
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, "rel");

        step(1'b0, 1'b1, 58'd12, 58'd12, 116'd144, 1'b0, "12x12");
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, "idle");
        step(1'b0, 1'b1, 58'd2, 58'd1, 116'd2, 1'b0, "2x1");
        step(1'b0, 1'b1, 58'd0, 58'd12, 116'd0, 1'b0, "0x12");
        step(1'b0, 1'b1, mul_op_t'(1) << 53, mul_op_t'(511) << 38,
             mul_prod_t'(511) << 91, 1'b0, "single_bits");
        e_ext = '1;
        e_ext = e_ext - (mul_prod_t'(1) << 59) + mul_prod_t'(2);
        step(1'b0, 1'b1, '1, '1, e_ext, 1'b0, "all_ones");
        pa = 58'h2AAAAAAAAAAAAAA;
        pb = 58'h3CCCCCCCCCCCCCC;
        step(1'b0, 1'b1, pa, pb, mul_prod_t'(pa) * mul_prod_t'(pb), 1'b0, "pattern");

        for (int i = 0; i < 1000; i++) begin
            ra = mul_op_t'({$urandom(), $urandom()});
            rb = mul_op_t'({$urandom(), $urandom()});
            step(1'b0, $urandom_range(0, 3) != 0, ra, rb,
                 mul_prod_t'(ra) * mul_prod_t'(rb), 1'b0, "stream");
        end
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, "drain");
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, "drain");

        step(1'b0, 1'b1, 58'd1000, 58'd3, 116'd3000, 1'b0, "flight1");
        step(1'b1, 1'b1, 58'd77, 58'd9, 116'd693, 1'b0, "flight2");
        step(1'b0, 1'b0, '0, '0, '0, 1'b0, "after_rst");
        step(1'b0, 1'b1, 58'd123456, 58'd654321, 116'd80779853376, 1'b0, "post_rst");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, '0, '0, 1'b0, "drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
